// File: rtl/mult_bist_pkg.sv
// Shared types and constants for the multiplier BIST sequencer.
// Stuck-signature abort logic exists only when MULT_BIST_STUCK_CHECK_EN is defined.
package mult_bist_pkg;

    localparam int CNT_W = 16;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DUT_RST,
        ST_RUN,
        ST_COMPARE,
        ST_DONE
    } bist_state_t;

    localparam logic [1:0] FAIL_NONE     = 2'b00;
    localparam logic [1:0] FAIL_MISMATCH = 2'b01;
    localparam logic [1:0] FAIL_STUCK    = 2'b10;

endpackage

// File: rtl/mult_bist_stuck_det.sv
// Flags a signature that has stayed unchanged for STUCK_LIMIT consecutive compared cycles.
// Instantiated by mult_bist_ctrl only when MULT_BIST_STUCK_CHECK_EN is defined.
module mult_bist_stuck_det
    import mult_bist_pkg::*;
#(
    parameter int STUCK_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] signature,
    output logic        stuck
);

    logic [15:0] prev_sig;
    logic        prev_valid;
    cnt_t        eq_cnt;
    logic        same;

    localparam cnt_t EQ_LAST = cnt_t'(STUCK_LIMIT - 1);

    // The first enabled cycle only loads prev_sig; comparisons start on the next one.
    assign same  = prev_valid && (signature == prev_sig);
    assign stuck = en && same && (eq_cnt == EQ_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_sig   <= 16'h0000;
            prev_valid <= 1'b0;
            eq_cnt     <= '0;
        end else if (!en) begin
            prev_valid <= 1'b0;
            eq_cnt     <= '0;
        end else begin
            prev_sig   <= signature;
            prev_valid <= 1'b1;
            eq_cnt     <= same ? eq_cnt + cnt_t'(1) : '0;
        end
    end

endmodule

// File: rtl/mult_bist_ctrl.sv
// BIST sequencer: resets the multiplier test block, runs it, captures and judges its signature.
// Optional stuck-signature abort is enabled by defining MULT_BIST_STUCK_CHECK_EN.
module mult_bist_ctrl
    import mult_bist_pkg::*;
#(
    parameter int          RESET_CYCLES = 4,
    parameter int          RUN_CYCLES   = 1000,
    parameter logic [15:0] GOLDEN_SIG   = 16'hA5C3,
    parameter int          STUCK_LIMIT  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] signature,
    output logic        dut_reset,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [1:0]  fail_code,
    output logic [15:0] sig_capture,
    output bist_state_t state_dbg
);

    localparam cnt_t RST_LAST = cnt_t'(RESET_CYCLES - 1);
    localparam cnt_t RUN_LAST = cnt_t'(RUN_CYCLES - 1);

    if (RESET_CYCLES < 1 || RUN_CYCLES < 1 || RUN_CYCLES > 65535 || STUCK_LIMIT < 2) begin : g_bad_params
        $error("mult_bist_ctrl: parameter out of legal range");
    end

    bist_state_t state;
    cnt_t        cnt;
    logic        stuck;

    assign state_dbg = state;

`ifdef MULT_BIST_STUCK_CHECK_EN
    mult_bist_stuck_det #(
        .STUCK_LIMIT(STUCK_LIMIT)
    ) u_stuck_det (
        .clk      (clk),
        .reset    (reset),
        .en       (state == ST_RUN),
        .signature(signature),
        .stuck    (stuck)
    );
`else
    assign stuck = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            dut_reset   <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_code   <= FAIL_NONE;
            sig_capture <= 16'h0000;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    // A new run drops the previous verdict on the accepting edge.
                    if (start) begin
                        state     <= ST_DUT_RST;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        fail_code <= FAIL_NONE;
                    end
                end
                ST_DUT_RST: begin
                    if (cnt == RST_LAST) begin
                        state     <= ST_RUN;
                        cnt       <= '0;
                        dut_reset <= 1'b0;
                    end else begin
                        cnt <= cnt + cnt_t'(1);
                    end
                end
                ST_RUN: begin
                    if (stuck) begin
                        state       <= ST_DONE;
                        sig_capture <= signature;
                        pass        <= 1'b0;
                        fail_code   <= FAIL_STUCK;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        dut_reset   <= 1'b1;
                    end else if (cnt == RUN_LAST) begin
                        state       <= ST_COMPARE;
                        sig_capture <= signature;
                        dut_reset   <= 1'b1;
                    end else begin
                        cnt <= cnt + cnt_t'(1);
                    end
                end
                ST_COMPARE: begin
                    state     <= ST_DONE;
                    pass      <= (sig_capture == GOLDEN_SIG);
                    fail_code <= (sig_capture == GOLDEN_SIG) ? FAIL_NONE : FAIL_MISMATCH;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    dut_reset <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
